// File: rtl/gate_sweep_ctrl_if.sv
// rtl/gate_sweep_ctrl_if.sv - gate sweep sequencer handshake and gate pin bundle
interface gate_sweep_ctrl_if;
  logic       start;
  logic       gate_c;
  logic       gate_a;
  logic       gate_b;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] fail_mask;
  logic [3:0] result_vec;

  // The sequencer itself: consumes start and the gate output, drives everything else
  modport slave (
    input  start,
    input  gate_c,
    output gate_a,
    output gate_b,
    output busy,
    output done,
    output pass,
    output fail_mask,
    output result_vec
  );

  // The requester plus the gate under test
  modport master (
    output start,
    output gate_c,
    input  gate_a,
    input  gate_b,
    input  busy,
    input  done,
    input  pass,
    input  fail_mask,
    input  result_vec
  );
endinterface

// File: rtl/gate_sweep_ctrl.sv
// rtl/gate_sweep_ctrl.sv - truth-table sweep sequencer for a 2-input gate
module gate_sweep_ctrl #(
  parameter int         HOLD_CYCLES = 4,
  parameter logic [3:0] EXPECTED    = 4'b1110
) (
  input  logic              clk,
  input  logic              rst,
  gate_sweep_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Terminal hold count; cnt is 8 bits so any legal HOLD_CYCLES fits without wrap
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  state_t     r_state;
  state_t     w_next;
  logic [1:0] r_idx;
  logic [7:0] r_cnt;
  logic       r_gate_a;
  logic       r_gate_b;
  logic       r_busy;
  logic       r_done;
  logic       r_pass;
  logic [3:0] r_fail_mask;
  logic [3:0] r_result_vec;

  logic       w_last;
  logic [1:0] w_idx_next;
  logic [7:0] w_cnt_next;
  logic [3:0] w_result_next;
  logic [3:0] w_fail_next;
  logic       w_pass_next;
  logic       w_busy_next;
  logic       w_done_next;
  logic       w_gate_a_next;
  logic       w_gate_b_next;

  // Last hold cycle of the current vector: the only point gate_c is sampled
  assign w_last = (r_state == S_DRIVE) && (r_cnt == HOLD_LAST);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = S_DRIVE;
      S_DRIVE: if (w_last && (r_idx == 2'd3)) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Output and datapath next values; outputs are registered from the next state
  // so gate pins and status change cleanly on the clock edge
  always_comb begin
    w_idx_next    = r_idx;
    w_cnt_next    = r_cnt;
    w_result_next = r_result_vec;
    w_fail_next   = r_fail_mask;
    w_pass_next   = r_pass;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_idx_next    = 2'd0;
          w_cnt_next    = 8'd0;
          w_result_next = 4'b0000;
          w_fail_next   = 4'b0000;
          w_pass_next   = 1'b0;
        end
      end
      S_DRIVE: begin
        if (w_last) begin
          w_cnt_next           = 8'd0;
          w_result_next[r_idx] = bus.gate_c;
          w_fail_next[r_idx]   = bus.gate_c ^ EXPECTED[r_idx];
          if (r_idx == 2'd3) begin
            // Verdict includes the vector-3 mismatch captured on this same edge
            w_pass_next = (w_fail_next == 4'b0000);
          end else begin
            w_idx_next = r_idx + 2'd1;
          end
        end else begin
          w_cnt_next = r_cnt + 8'd1;
        end
      end
      default: ;
    endcase
    w_busy_next   = (w_next == S_DRIVE);
    w_done_next   = (w_next == S_DONE);
    w_gate_a_next = w_busy_next & w_idx_next[1];
    w_gate_b_next = w_busy_next & w_idx_next[0];
  end

  // Datapath and output registers; reset discards any partial sweep
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx        <= 2'd0;
      r_cnt        <= 8'd0;
      r_gate_a     <= 1'b0;
      r_gate_b     <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_fail_mask  <= 4'b0000;
      r_result_vec <= 4'b0000;
    end else begin
      r_idx        <= w_idx_next;
      r_cnt        <= w_cnt_next;
      r_gate_a     <= w_gate_a_next;
      r_gate_b     <= w_gate_b_next;
      r_busy       <= w_busy_next;
      r_done       <= w_done_next;
      r_pass       <= w_pass_next;
      r_fail_mask  <= w_fail_next;
      r_result_vec <= w_result_next;
    end
  end

  assign bus.gate_a     = r_gate_a;
  assign bus.gate_b     = r_gate_b;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.pass       = r_pass;
  assign bus.fail_mask  = r_fail_mask;
  assign bus.result_vec = r_result_vec;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// tb/tb_gate_sweep_ctrl.sv - directed bench for gate_sweep_ctrl
module tb_gate_sweep_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   gate_mode = 0;  // 0 = OR gate, 1 = AND gate, 2 = output stuck at 0

  always #5 clk = ~clk;

  gate_sweep_ctrl_if bus ();
  gate_sweep_ctrl_if bus1 ();

  assign bus.gate_c  = (gate_mode == 0) ? (bus.gate_a | bus.gate_b) :
                       (gate_mode == 1) ? (bus.gate_a & bus.gate_b) : 1'b0;
  assign bus1.gate_c = bus1.gate_a | bus1.gate_b;

  gate_sweep_ctrl #(.HOLD_CYCLES(4), .EXPECTED(4'b1110)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  gate_sweep_ctrl #(.HOLD_CYCLES(1), .EXPECTED(4'b1110)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  // Pulse start on dut and observe 40 cycles of activity
  task automatic run_sweep(input int extra_at, output int busy_len, output int done_cnt,
                           output int ab_bad, output int first_busy, output int done_follows,
                           output int cleared_ok);
    logic prev_busy;
    busy_len = 0; done_cnt = 0; ab_bad = 0; done_follows = 0; cleared_ok = 0;
    bus.start = 1'b1;
    @(negedge clk);
    first_busy = int'(bus.busy);
    prev_busy = 1'b0;
    for (int c = 0; c < 40; c++) begin
      bus.start = 1'b0;
      if (bus.busy) begin
        busy_len++;
        if ({bus.gate_a, bus.gate_b} !== 2'((busy_len - 1) / 4)) ab_bad++;
        if (busy_len == 1 && bus.pass === 1'b0 && bus.fail_mask === 4'b0000 &&
            bus.result_vec === 4'b0000) cleared_ok = 1;
        if (busy_len == extra_at) bus.start = 1'b1;
      end else if ((bus.gate_a | bus.gate_b) !== 1'b0) begin
        ab_bad++;
      end
      if (bus.done) begin
        done_cnt++;
        if (prev_busy) done_follows = 1;
      end
      prev_busy = bus.busy;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    bus.start = 1'b0; bus1.start = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.gate_a, bus.gate_b, bus.busy, bus.done, bus.pass, bus.fail_mask, bus.result_vec} !== 13'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 0", {bus.gate_a, bus.gate_b, bus.busy, bus.done, bus.pass, bus.fail_mask, bus.result_vec});
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk); @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.gate_a, bus.gate_b} !== 4'd0) begin
      errors++;
      $display("FAIL idle_after_reset: got %b expected 0000", {bus.busy, bus.done, bus.gate_a, bus.gate_b});
    end
  endtask

  task automatic test_sweep(input string name, input int mode, input int extra_at,
                            input logic [3:0] exp_res, input logic [3:0] exp_fail, input logic exp_pass);
    int bl, dc, ab, fb, df, cl;
    gate_mode = mode;
    run_sweep(extra_at, bl, dc, ab, fb, df, cl);
    checks++; if (fb !== 1) begin errors++; $display("FAIL %s busy_rise: got %0d expected 1", name, fb); end
    checks++; if (bl !== 16) begin errors++; $display("FAIL %s busy_len: got %0d expected 16", name, bl); end
    checks++; if (dc !== 1) begin errors++; $display("FAIL %s done_count: got %0d expected 1", name, dc); end
    checks++; if (df !== 1) begin errors++; $display("FAIL %s done_after_busy: got %0d expected 1", name, df); end
    checks++; if (ab !== 0) begin errors++; $display("FAIL %s gate_ab_seq: got %0d bad cycles expected 0", name, ab); end
    checks++; if (cl !== 1) begin errors++; $display("FAIL %s cleared_at_start: got %0d expected 1", name, cl); end
    checks++; if (bus.result_vec !== exp_res) begin errors++; $display("FAIL %s result_vec: got %b expected %b", name, bus.result_vec, exp_res); end
    checks++; if (bus.fail_mask !== exp_fail) begin errors++; $display("FAIL %s fail_mask: got %b expected %b", name, bus.fail_mask, exp_fail); end
    checks++; if (bus.pass !== exp_pass) begin errors++; $display("FAIL %s pass: got %b expected %b", name, bus.pass, exp_pass); end
  endtask

  task automatic test_or_sweep;
    test_sweep("or_sweep", 0, 0, 4'b1110, 4'b0000, 1'b1);
  endtask

  task automatic test_and_sweep;
    test_sweep("and_sweep", 1, 0, 4'b1000, 4'b0110, 1'b0);
  endtask

  task automatic test_stuck_zero;
    test_sweep("stuck_zero", 2, 0, 4'b0000, 4'b1110, 1'b0);
  endtask

  task automatic test_ignored_start;
    test_sweep("ignored_start", 0, 5, 4'b1110, 4'b0000, 1'b1);
  endtask

  task automatic test_reset_mid;
    int n, dc;
    gate_mode = 2;
    n = 0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (bus.busy) n++;
      if (n == 7) break;
      @(negedge clk);
    end
    checks++;
    if (n !== 7) begin errors++; $display("FAIL reset_mid_reach: got %0d busy cycles expected 7", n); end
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.gate_a, bus.gate_b, bus.busy, bus.done, bus.pass, bus.fail_mask, bus.result_vec} !== 13'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got %b expected 0", {bus.gate_a, bus.gate_b, bus.busy, bus.done, bus.pass, bus.fail_mask, bus.result_vec});
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    dc = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus.done || bus.busy) dc++;
    end
    checks++;
    if (dc !== 0) begin errors++; $display("FAIL reset_mid_no_done: got %0d active cycles expected 0", dc); end
    test_sweep("after_reset", 0, 0, 4'b1110, 4'b0000, 1'b1);
  endtask

  task automatic test_back_to_back;
    int exp_code, got_code;
    @(negedge clk);
    bus1.start = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (k == 11) bus1.start = 1'b0;
      exp_code = (k < 4 || (k >= 6 && k < 10)) ? 1 : ((k == 4 || k == 10) ? 2 : 0);
      got_code = (bus1.busy ? 1 : 0) + (bus1.done ? 2 : 0);
      checks++;
      if (got_code !== exp_code) begin
        errors++;
        $display("FAIL b2b_state[%0d]: got %0d expected %0d", k, got_code, exp_code);
      end
      if (exp_code == 1) begin
        checks++;
        if ({bus1.gate_a, bus1.gate_b} !== 2'((k < 4) ? k : k - 6)) begin
          errors++;
          $display("FAIL b2b_gate_ab[%0d]: got %b expected %0d", k, {bus1.gate_a, bus1.gate_b}, (k < 4) ? k : k - 6);
        end
      end
      if (exp_code == 2) begin
        checks++;
        if ({bus1.pass, bus1.fail_mask, bus1.result_vec} !== 9'b1_0000_1110) begin
          errors++;
          $display("FAIL b2b_result[%0d]: got %b expected 100001110", k, {bus1.pass, bus1.fail_mask, bus1.result_vec});
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_or_sweep();
    test_and_sweep();
    test_stuck_zero();
    test_ignored_start();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
